// File: rtl/retire_serializer_pkg.sv
// Shared definitions for the retirement trace path: record layout and packing helper.
package retire_serializer_pkg;

    localparam int RETIRE_W     = 70;
    localparam int RT_PC_LSB    = 0;
    localparam int RT_WDATA_LSB = 32;
    localparam int RT_WADDR_LSB = 64;
    localparam int RT_RFEN_BIT  = 69;

    typedef logic [RETIRE_W-1:0] retire_rec_t;

    function automatic retire_rec_t pack_retire(
        input logic        rf_en,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] pc
    );
        retire_rec_t rec;
        rec                        = '0;
        rec[RT_PC_LSB +: 32]       = pc;
        rec[RT_WDATA_LSB +: 32]    = wdata;
        rec[RT_WADDR_LSB +: 5]     = waddr;
        rec[RT_RFEN_BIT]           = rf_en;
        return rec;
    endfunction

endpackage

// File: rtl/retire_fifo2w1r.sv
// DEPTH-entry FIFO accepting up to two records per cycle (a before b) and releasing one.
module retire_fifo2w1r
    import retire_serializer_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = RETIRE_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_push_cnt,
    input  logic [W-1:0]  i_push_a,
    input  logic [W-1:0]  i_push_b,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_ptr_b;

    assign w_wr_ptr_b = r_wr_ptr + AW'(1);

    // Pointers wrap naturally; occupancy is tracked only by r_count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + CW'(i_push_cnt) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push_cnt != 2'd0) r_mem[r_wr_ptr]   <= i_push_a;
        if (i_push_cnt == 2'd2) r_mem[w_wr_ptr_b] <= i_push_b;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/retire_serializer.sv
// Serializes dual-lane retirements into one in-order record per cycle on inst_retire.
module retire_serializer
    import retire_serializer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic                l0_valid,
    input  logic [31:0]         l0_pc,
    input  logic                l0_rf_en,
    input  logic [4:0]          l0_waddr,
    input  logic [31:0]         l0_wdata,
    input  logic                l1_valid,
    input  logic [31:0]         l1_pc,
    input  logic                l1_rf_en,
    input  logic [4:0]          l1_waddr,
    input  logic [31:0]         l1_wdata,
    output logic                in_ready,
    output logic [RETIRE_W-1:0] inst_retire,
    output logic                rt_valid,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic                overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    retire_rec_t      w_rec0;
    retire_rec_t      w_rec1;
    retire_rec_t      w_fifo_head;
    retire_rec_t      w_head;
    retire_rec_t      w_push_a;
    retire_rec_t      w_push_b;
    logic [CW-1:0]    w_count;
    logic             w_in_ready;
    logic             w_v0;
    logic             w_v1;
    logic             w_head_vld;
    logic             w_pop;
    logic [1:0]       w_push_cnt;

    retire_rec_t      r_inst_retire;
    logic             r_rt_valid;
    logic [CNT_W-1:0] r_retired_cnt;
    logic             r_overflow_err;

    assign w_rec0 = pack_retire(l0_rf_en, l0_waddr, l0_wdata, l0_pc);
    assign w_rec1 = pack_retire(l1_rf_en, l1_waddr, l1_wdata, l1_pc);

    // Readiness ignores the same-cycle pop, so two free slots are always real.
    assign w_in_ready = (w_count <= CW'(DEPTH - 2));
    assign w_v0       = l0_valid & w_in_ready;
    assign w_v1       = l1_valid & w_in_ready;

    always_comb begin
        w_head     = '0;
        w_head_vld = 1'b0;
        w_pop      = 1'b0;
        w_push_cnt = 2'd0;
        w_push_a   = w_rec0;
        w_push_b   = w_rec1;
        if (w_count != '0) begin
            w_head     = w_fifo_head;
            w_head_vld = 1'b1;
            w_pop      = 1'b1;
            w_push_cnt = {1'b0, w_v0} + {1'b0, w_v1};
            w_push_a   = w_v0 ? w_rec0 : w_rec1;
        end else if (w_v0) begin
            // Empty FIFO: lane 0 bypasses straight to the output register.
            w_head     = w_rec0;
            w_head_vld = 1'b1;
            w_push_cnt = {1'b0, w_v1};
            w_push_a   = w_rec1;
        end else if (w_v1) begin
            w_head     = w_rec1;
            w_head_vld = 1'b1;
        end
    end

    retire_fifo2w1r #(
        .DEPTH (DEPTH),
        .W     (RETIRE_W)
    ) u_fifo (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_reset_n),
        .i_push_cnt (w_push_cnt),
        .i_push_a   (w_push_a),
        .i_push_b   (w_push_b),
        .i_pop      (w_pop),
        .o_head     (w_fifo_head),
        .o_count    (w_count)
    );

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_inst_retire  <= '0;
            r_rt_valid     <= 1'b0;
            r_retired_cnt  <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_inst_retire  <= w_head;
            r_rt_valid     <= w_head_vld;
            if (w_head_vld) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            if ((l0_valid | l1_valid) & ~w_in_ready) r_overflow_err <= 1'b1;
        end
    end

    assign in_ready     = w_in_ready;
    assign inst_retire  = r_inst_retire;
    assign rt_valid     = r_rt_valid;
    assign retired_cnt  = r_retired_cnt;
    assign overflow_err = r_overflow_err;

endmodule
